uart_tx_arbiter: RTL

//   Round-robin arbiter and sequencer that shares the single board UART transmitter (txd path)

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for the shared UART TX arbiter.
// slave is the arbiter's view; master is the requesters-plus-serializer side.
interface uart_tx_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8
);
   localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_last;
   logic [N_REQ-1:0]        req_ready;
   logic                    tx_start;
   logic [DATA_W-1:0]       tx_data;
   logic                    tx_busy;
   logic [GID_W-1:0]        grant_id;
   logic                    grant_active;
   logic                    err_ack_timeout;

   modport slave (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_start, tx_data, grant_id, grant_active, err_ack_timeout
   );

   modport master (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, tx_start, tx_data, grant_id, grant_active, err_ack_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte streams; a grant
// lasts for a whole message (req_last) or MAX_BURST bytes, each byte acked via tx_busy.
//
// state     | meaning
// IDLE      | no grant; pick next valid requester after ptr
// ISSUE     | granted requester may hand over a byte once tx is idle
// WAIT_ACK  | tx_start pulsed, waiting for tx_busy to rise (bounded)
// WAIT_DONE | waiting for tx_busy to fall, then continue or release
module uart_tx_arbiter #(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = 8,
   parameter int MAX_BURST   = 16,
   parameter int ACK_TIMEOUT = 8
) (
   input logic              clk,
   input logic              reset_btn_n,
   uart_tx_arbiter_if.slave bus
);
   localparam int GID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
   localparam int ACK_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_ACK  = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [GID_W-1:0]    ptr, gid, pick, cand;
   logic                act, start_q, last_q, err_q;
   logic [DATA_W-1:0]   data_q, gnt_data;
   logic                gnt_valid, gnt_last;
   logic [BURST_W-1:0]  burst, burst_inc;
   logic [ACK_W-1:0]    ack_cnt;
   logic                do_grant, do_hs, do_done, do_release, do_timeout;

   // Descending scan so the nearest requester after ptr wins.
   always_comb begin
      pick = ptr;
      cand = ptr;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = GID_W'((int'(ptr) + k) % N_REQ);
         if (bus.req_valid[cand]) pick = cand;
      end
   end

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gid == GID_W'(i)) gnt_data = bus.req_data[i*DATA_W +: DATA_W];
      end
   end

   assign gnt_valid = bus.req_valid[gid];
   assign gnt_last  = bus.req_last[gid];

   always_comb begin
      bus.req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (state == ISSUE && !bus.tx_busy && gid == GID_W'(i)) bus.req_ready[i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_btn_n) state <= IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      do_grant   = 1'b0;
      do_hs      = 1'b0;
      do_done    = 1'b0;
      do_release = 1'b0;
      do_timeout = 1'b0;
      burst_inc  = (burst == '1) ? burst : burst + 1'b1;
      unique case (state)
         IDLE: begin
            if (|bus.req_valid) begin
               do_grant  = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (!gnt_valid) begin
               do_release = 1'b1;
               state_nxt  = IDLE;
            end else if (!bus.tx_busy) begin
               do_hs     = 1'b1;
               state_nxt = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (bus.tx_busy) begin
               state_nxt = WAIT_DONE;
            end else if (ack_cnt == '0) begin
               do_timeout = 1'b1;
               state_nxt  = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) begin
               do_done = 1'b1;
               if (last_q || (MAX_BURST != 0 && burst_inc == BURST_W'(MAX_BURST))) begin
                  do_release = 1'b1;
                  state_nxt  = IDLE;
               end else begin
                  state_nxt = ISSUE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_btn_n) begin
         ptr     <= GID_W'(N_REQ - 1);
         gid     <= '0;
         act     <= 1'b0;
         start_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
         err_q   <= 1'b0;
         burst   <= '0;
         ack_cnt <= '0;
      end else begin
         start_q <= do_hs;
         if (do_grant) begin
            gid   <= pick;
            act   <= 1'b1;
            burst <= '0;
         end
         // Ack timer counts down from ACK_TIMEOUT-1; terminal count is zero.
         if (do_hs) begin
            data_q  <= gnt_data;
            last_q  <= gnt_last;
            ack_cnt <= ACK_W'(ACK_TIMEOUT - 1);
         end else if (state == WAIT_ACK && ack_cnt != '0) begin
            ack_cnt <= ack_cnt - 1'b1;
         end
         if (do_timeout) err_q <= 1'b1;
         if (do_done)    burst <= burst_inc;
         if (do_release) begin
            act <= 1'b0;
            ptr <= gid;
         end
      end
   end

   assign bus.tx_start        = start_q;
   assign bus.tx_data         = data_q;
   assign bus.grant_id        = gid;
   assign bus.grant_active    = act;
   assign bus.err_ack_timeout = err_q;
endmodule
